ifft_s2p: RTL and testbench

- Serial-to-parallel collector at the IFFT input of the NB-IoT LTE transmitter; the counterpart of the IFFT output parallel-to-serial stage.
- Accepts one 16-bit fixed-point sample per handshake and assembles N samples into a frame.
- Presents the complete frame as a parallel word held in an output register until the IFFT core acknowledges it.
- Collection of the next frame overlaps with the hold of the current one.

---
 rtl/ifft_s2p.sv | 160 ++++++++++++++++
 tb/tb_ifft_s2p.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_s2p.sv
// ifft_s2p: serial-to-parallel collector feeding the IFFT core.
// Gathers N samples of DW bits into a frame and holds the frame in an output
// register until out_ack; the next frame is collected during the hold.
// Optional macro IFFT_S2P_SOP_EN adds the sop input (start-of-frame marker)
// and the sticky frame_err output.
module ifft_s2p #(
  parameter int DW = 16,
  parameter int N  = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   data_in,
  output logic [3:0]      count,
  output logic            out_valid,
  input  logic            out_ack,
  output logic [N*DW-1:0] out_data
`ifdef IFFT_S2P_SOP_EN
  ,
  input  logic            sop,
  output logic            frame_err
`endif
);

  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  out_state_t        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [N*DW-1:0]   out_data_q;
  logic [N*DW-1:0]   frame_w;
  logic [DW-1:0]     collect_q [N-1];
  logic              sop_w;
  logic              accept;
  logic              complete;
  logic              load_out;
  logic [3:0]        wr_idx;

`ifdef IFFT_S2P_SOP_EN
  assign sop_w = sop;
`else
  assign sop_w = 1'b0;
`endif

  // Only the completing sample can stall; the ack frees the register in the
  // same cycle so the completing sample passes straight through.
  assign in_ready = !((count_q == LAST) && (state_q == OUT_FULL) && !out_ack);
  assign accept   = in_valid && in_ready;
  // A sop sample always restarts at index 0, so it never completes a frame.
  assign complete = accept && !sop_w && (count_q == LAST);
  assign wr_idx   = sop_w ? 4'd0 : count_q;

  assign count     = count_q;
  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = out_data_q;

  // The last slot is never stored: the completing sample is merged straight
  // from data_in into the frame loaded into the output register.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      if (gi == N - 1) begin : g_last
        assign frame_w[gi*DW +: DW] = data_in;
      end else begin : g_buf
        assign frame_w[gi*DW +: DW] = collect_q[gi];

        // Direct-index write of an accepted sample into its collect slot.
        always_ff @(posedge clk) begin
          if (rst) begin
            collect_q[gi] <= '0;
          end else if (accept && (wr_idx == 4'(gi))) begin
            collect_q[gi] <= data_in;
          end
        end
      end
    end
  endgenerate

  // Next write index: advances per accepted sample, wraps after N-1, and
  // snaps to 1 when a sop sample lands in slot 0.
  always_comb begin
    count_d = count_q;
    if (accept) begin
      if (sop_w) begin
        count_d = 4'd1;
      end else if (count_q == LAST) begin
        count_d = 4'd0;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // Sample-index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Output FSM: a completing frame always loads (even on the ack edge, giving
  // back-to-back frames); otherwise an ack empties the register.
  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          state_d  = OUT_FULL;
          load_out = 1'b1;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          load_out = 1'b1;
        end else if (out_ack) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output frame register; holds its value until the next frame loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (load_out) begin
      out_data_q <= frame_w;
    end
  end

`ifdef IFFT_S2P_SOP_EN
  logic frame_err_q;

  assign frame_err = frame_err_q;

  // Sticky framing error: sop in mid-frame, or a frame starting without sop.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else if (accept && ((sop && (count_q != 4'd0)) || (!sop && (count_q == 4'd0)))) begin
      frame_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifft_s2p.sv
// Testbench for ifft_s2p: directed vector table plus hand-written sequences
// for back-to-back streaming, mid-frame reset and (optionally) sop framing.
module tb_ifft_s2p;

  localparam int DW = 16;
  localparam int N  = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   data_in;
  logic [3:0]      count;
  logic            out_valid;
  logic            out_ack;
  logic [N*DW-1:0] out_data;
`ifdef IFFT_S2P_SOP_EN
  logic            sop;
  logic            frame_err;
`endif

  ifft_s2p #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .count     (count),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_data  (out_data)
`ifdef IFFT_S2P_SOP_EN
    ,
    .sop       (sop),
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [15:0] din;
    logic        ack;
    logic        exp_rdy;
    logic [3:0]  exp_cnt;
    logic        exp_ov;
    logic        chk_data;
    logic [15:0] exp_w0;
    logic [15:0] exp_w11;
  } vec_t;

  vec_t vecs [64];
  int   n_vec = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [15:0] din, input logic ack, input logic rdy,
                     input logic [3:0] cnt, input logic ov, input logic cd,
                     input logic [15:0] w0, input logic [15:0] w11);
    vecs[n_vec] = '{vld, din, ack, rdy, cnt, ov, cd, w0, w11};
    n_vec++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ack = 1'b0; data_in = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One accepted-or-not transfer: drive at negedge, sample #1 after posedge.
  task automatic xfer(input logic vld, input logic [15:0] din, input logic ack);
    @(negedge clk);
    in_valid = vld; data_in = din; out_ack = ack;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0]   mbuf [N];
  logic [N*DW-1:0] exp_frame;
  int              mcnt;
  logic            mcomplete;

  initial begin
    rst = 1'b0; in_valid = 1'b0; data_in = '0; out_ack = 1'b0;
`ifdef IFFT_S2P_SOP_EN
    sop = 1'b0;
`endif

    // Frame 1: 0x0001..0x000C, ack low.
    for (int i = 1; i <= 12; i++)
      add(1'b1, 16'(i), 1'b0, 1'b1, 4'(i % 12), (i == 12), 1'b1,
          (i == 12) ? 16'h0001 : 16'h0000, (i == 12) ? 16'h000C : 16'h0000);
    // Frame 2 first 11 samples while frame 1 is held.
    for (int i = 1; i <= 11; i++)
      add(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1, 4'(i), 1'b1, 1'b1, 16'h0001, 16'h000C);
    // Completing sample stalls without ack, then passes with ack.
    add(1'b1, 16'h010C, 1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 16'h0001, 16'h000C);
    add(1'b1, 16'h010C, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 16'h0101, 16'h010C);
    // Idle ack drains the register.
    add(1'b0, 16'h0000, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 16'h0000, 16'h0000);
    // Gapped frame 0x0201..0x020C.
    for (int i = 1; i <= 12; i++) begin
      add(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b1, 4'(i % 12), (i == 12), (i == 12),
          16'h0201, 16'h020C);
      add(1'b0, 16'hDEAD, 1'b0, 1'b1, 4'(i % 12), (i == 12), (i == 12),
          16'h0201, 16'h020C);
    end

    do_reset();
    #1;
    check("reset_count", 192'(count), 192'(0));
    check("reset_out_valid", 192'(out_valid), 192'(0));
    check("reset_out_data", out_data, '0);
    check("reset_in_ready", 192'(in_ready), 192'(1));

    for (int v = 0; v < n_vec; v++) begin
      @(negedge clk);
      in_valid = vecs[v].vld; data_in = vecs[v].din; out_ack = vecs[v].ack;
      #1;
      check($sformatf("vec%0d_in_ready", v), 192'(in_ready), 192'(vecs[v].exp_rdy));
      @(posedge clk);
      #1;
      $display("[TB] vec %0d vld=%0b din=%h ack=%0b -> cnt=%0d ov=%0b w0=%h w11=%h",
               v, vecs[v].vld, vecs[v].din, vecs[v].ack, count, out_valid,
               out_data[15:0], out_data[191:176]);
      check($sformatf("vec%0d_count", v), 192'(count), 192'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_out_valid", v), 192'(out_valid), 192'(vecs[v].exp_ov));
      if (vecs[v].chk_data) begin
        check($sformatf("vec%0d_w0", v), 192'(out_data[15:0]), 192'(vecs[v].exp_w0));
        check($sformatf("vec%0d_w11", v), 192'(out_data[191:176]), 192'(vecs[v].exp_w11));
      end
    end

    // Back-to-back streaming, ack held high, scoreboard over 4 frames.
    mcnt = 0;
    for (int c = 0; c < 4 * N; c++) begin
      @(negedge clk);
      in_valid = 1'b1; data_in = 16'($urandom); out_ack = 1'b1;
      #1;
      check($sformatf("b2b%0d_in_ready", c), 192'(in_ready), 192'(1));
      mbuf[mcnt] = data_in;
      mcomplete = (mcnt == N - 1);
      mcnt = (mcnt + 1) % N;
      @(posedge clk);
      #1;
      $display("[TB] b2b %0d din=%h -> cnt=%0d ov=%0b", c, mbuf[(mcnt + N - 1) % N], count, out_valid);
      check($sformatf("b2b%0d_count", c), 192'(count), 192'(mcnt));
      check($sformatf("b2b%0d_out_valid", c), 192'(out_valid), 192'(mcomplete));
      if (mcomplete) begin
        for (int k = 0; k < N; k++) exp_frame[k*DW +: DW] = mbuf[k];
        check($sformatf("b2b%0d_frame", c), out_data, exp_frame);
      end
    end

    // Reset with a frame held and 5 samples collected.
    for (int i = 0; i < 5; i++) begin
      xfer(1'b1, 16'h0400 + 16'(i), 1'b0);
      $display("[TB] pre-reset sample %0d -> cnt=%0d ov=%0b", i, count, out_valid);
    end
    check("prerst_count", 192'(count), 192'(5));
    check("prerst_out_valid", 192'(out_valid), 192'(1));
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] mid-frame reset -> cnt=%0d ov=%0b", count, out_valid);
    check("midrst_out_valid", 192'(out_valid), 192'(0));
    check("midrst_out_data", out_data, '0);
    check("midrst_count", 192'(count), 192'(0));
    check("midrst_in_ready", 192'(in_ready), 192'(1));
    for (int i = 0; i < N; i++) begin
      xfer(1'b1, 16'h0301 + 16'(i), 1'b0);
      exp_frame[i*DW +: DW] = 16'h0301 + 16'(i);
      $display("[TB] post-reset sample %0d -> cnt=%0d ov=%0b", i, count, out_valid);
    end
    check("postrst_out_valid", 192'(out_valid), 192'(1));
    check("postrst_count", 192'(count), 192'(0));
    check("postrst_frame", out_data, exp_frame);

`ifdef IFFT_S2P_SOP_EN
    // sop arriving mid-frame restarts the frame and flags an error.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sop = (i == 0);
      xfer(1'b1, 16'h0500 + 16'(i), 1'b1);
      $display("[TB] sop-test sample %0d -> cnt=%0d err=%0b", i, count, frame_err);
    end
    check("sop_pre_err", 192'(frame_err), 192'(0));
    check("sop_pre_count", 192'(count), 192'(7));
    sop = 1'b1;
    xfer(1'b1, 16'hAAAA, 1'b1);
    sop = 1'b0;
    $display("[TB] sop sample AAAA -> cnt=%0d err=%0b", count, frame_err);
    check("sop_err", 192'(frame_err), 192'(1));
    check("sop_count", 192'(count), 192'(1));
    for (int i = 0; i < N - 1; i++) begin
      xfer(1'b1, 16'hB000 + 16'(i), 1'b1);
      $display("[TB] sop-frame sample %0d -> cnt=%0d ov=%0b", i, count, out_valid);
      if (i < N - 2) check($sformatf("sop_mid%0d_out_valid", i), 192'(out_valid), 192'(0));
    end
    check("sop_frame_valid", 192'(out_valid), 192'(1));
    check("sop_frame_w0", 192'(out_data[15:0]), 192'(16'hAAAA));
    check("sop_frame_w11", 192'(out_data[191:176]), 192'(16'hB00A));
    check("sop_err_sticky", 192'(frame_err), 192'(1));
`endif

    @(negedge clk);
    in_valid = 1'b0; out_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
